// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multicycle instruction fetch with req/ack memory handshake and PC redirect
module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] IRIn,
    output logic        IRWrite,
    input  logic        fetch_next,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic [15:0] pc,
    output logic        fetch_busy
);
    typedef enum logic {FETCH, WAIT} state_t;
    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] redir_addr_q;
    logic        req_q;
    logic        irw_q;
    logic        redir_pend_q;
    // Fetch FSM: FETCH with req low is the one-cycle launch after reset; a redirect seen
    // while a request is outstanding is parked until ack so the address stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= 16'h0000;
            redir_addr_q <= RESET_PC;
            req_q        <= 1'b0;
            irw_q        <= 1'b0;
            redir_pend_q <= 1'b0;
        end else begin
            irw_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                        if (pc_load) pc_q <= pc_target;
                    end else if (mem_ack) begin
                        if (pc_load || redir_pend_q) begin
                            pc_q         <= pc_load ? pc_target : redir_addr_q;
                            redir_pend_q <= 1'b0;
                        end else begin
                            ir_q    <= mem_rdata;
                            irw_q   <= 1'b1;
                            pc_q    <= pc_q + PC_STEP;
                            req_q   <= 1'b0;
                            state_q <= WAIT;
                        end
                    end else if (pc_load) begin
                        redir_pend_q <= 1'b1;
                        redir_addr_q <= pc_target;
                    end
                end
                WAIT: begin
                    if (pc_load || fetch_next) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        if (pc_load) pc_q <= pc_target;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end
    assign mem_addr   = pc_q;
    assign mem_req    = req_q;
    assign fetch_busy = req_q;
    assign IRIn       = ir_q;
    assign IRWrite    = irw_q;
    assign pc         = pc_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: vector table, hand sequence and randomized run against a transaction model
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] IRIn;
    logic        IRWrite;
    logic        fetch_next;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] pc;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .IRIn(IRIn), .IRWrite(IRWrite),
        .fetch_next(fetch_next), .pc_load(pc_load), .pc_target(pc_target),
        .pc(pc), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ack, fn, ld;
        logic [15:0] tgt, rd;
        logic        req;
        logic [15:0] pcv;
        logic        irw;
        logic [15:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an outstanding request either completes, or is retargeted
    // to the newest redirect address; idle waits for a launch trigger
    logic        m_busy, m_launch, m_wr;
    logic [15:0] m_pc, m_ir;
    int          m_tgt;

    task automatic model_edge();
        if (reset) begin
            m_busy = 0; m_launch = 1; m_wr = 0; m_pc = 16'h0000; m_ir = 16'h0000; m_tgt = -1;
        end else if (m_busy) begin
            m_wr = 0;
            if (mem_ack) begin
                if (pc_load || m_tgt >= 0) begin
                    m_pc  = pc_load ? pc_target : 16'(m_tgt);
                    m_tgt = -1;
                end else begin
                    m_ir = mem_rdata; m_wr = 1; m_pc = m_pc + 16'd2; m_busy = 0;
                end
            end else if (pc_load) m_tgt = int'(pc_target);
        end else begin
            m_wr = 0;
            if (m_launch || pc_load || fetch_next) begin
                if (pc_load) m_pc = pc_target;
                m_busy = 1; m_launch = 0;
            end
        end
    endtask

    initial begin
        int nwr;
        logic prev_wr;
        reset = 1; mem_ack = 0; fetch_next = 0; pc_load = 0; pc_target = 0; mem_rdata = 0;
        //              rst ack fn ld  tgt       rd        req pc        irw ir
        vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{1, 1, 0, 0, 16'h0000, 16'h1234, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h1234, 1, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h1234, 0, 16'h0002, 1, 16'h1234});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h9999, 0, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 16'h1234});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'hBEEF, 0, 16'h0004, 1, 16'hBEEF});
        vecs.push_back('{0, 0, 1, 1, 16'h0040, 16'h0000, 1, 16'h0040, 0, 16'hBEEF});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'hC0DE, 0, 16'h0042, 1, 16'hC0DE});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0042, 0, 16'hC0DE});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h0042, 0, 16'hC0DE});
        vecs.push_back('{0, 0, 0, 1, 16'h0080, 16'h0000, 1, 16'h0042, 0, 16'hC0DE});
        vecs.push_back('{0, 0, 0, 1, 16'h00A0, 16'h0000, 1, 16'h0042, 0, 16'hC0DE});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'hDEAD, 1, 16'h00A0, 0, 16'hC0DE});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h5A5A, 0, 16'h00A2, 1, 16'h5A5A});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h00A2, 0, 16'h5A5A});
        vecs.push_back('{0, 1, 0, 1, 16'hFFFE, 16'h1111, 1, 16'hFFFE, 0, 16'h5A5A});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h2222, 0, 16'h0000, 1, 16'h2222});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h2222});
        vecs.push_back('{1, 1, 0, 1, 16'h0300, 16'h3333, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 0, 0, 1, 16'h0100, 16'h0000, 1, 16'h0000, 0, 16'h0000});
        vecs.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000});
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 16'h4444, 0, 16'h0002, 1, 16'h4444});

        foreach (vecs[k]) begin
            reset = vecs[k].rst; mem_ack = vecs[k].ack; fetch_next = vecs[k].fn;
            pc_load = vecs[k].ld; pc_target = vecs[k].tgt; mem_rdata = vecs[k].rd;
            @(posedge clk); #1;
            chk($sformatf("vec%0d mem_req", k), 16'(mem_req), 16'(vecs[k].req));
            chk($sformatf("vec%0d fetch_busy", k), 16'(fetch_busy), 16'(vecs[k].req));
            chk($sformatf("vec%0d pc", k), pc, vecs[k].pcv);
            chk($sformatf("vec%0d IRWrite", k), 16'(IRWrite), 16'(vecs[k].irw));
            chk($sformatf("vec%0d IRIn", k), IRIn, vecs[k].ir);
            if (vecs[k].req) chk($sformatf("vec%0d mem_addr", k), mem_addr, vecs[k].pcv);
        end

        // Zero-wait memory with fetch_next held: one instruction every two edges from WAIT at pc=2
        reset = 0; mem_ack = 1; fetch_next = 1; pc_load = 0; mem_rdata = 16'h7777;
        nwr = 0; prev_wr = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (IRWrite && prev_wr) chk("irwrite_back_to_back", 16'd1, 16'd0);
            prev_wr = IRWrite;
            nwr += int'(IRWrite);
        end
        chk("stream_irwrite_count", 16'(nwr), 16'd4);
        chk("stream_pc", pc, 16'h000A);

        // Randomized run against the transaction model
        fetch_next = 0;
        for (int i = 0; i < 3000; i++) begin
            reset      = (i < 2) || ($urandom_range(0, 59) == 0);
            mem_ack    = 1'($urandom_range(0, 1));
            fetch_next = ($urandom_range(0, 3) == 0);
            pc_load    = ($urandom_range(0, 9) == 0);
            pc_target  = 16'($urandom);
            if (pc_load && $urandom_range(0, 3) == 0) pc_target = 16'hFFFE;
            mem_rdata  = 16'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd mem_req", 16'(mem_req), 16'(m_busy));
            chk("rnd fetch_busy", 16'(fetch_busy), 16'(m_busy));
            chk("rnd pc", pc, m_pc);
            chk("rnd IRWrite", 16'(IRWrite), 16'(m_wr));
            chk("rnd IRIn", IRIn, m_ir);
            if (m_busy) chk("rnd mem_addr", mem_addr, m_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
